rvv_backend_alu_rs: RTL
=======================

# rvv_backend_alu_rs

ALU reservation station for the RVV backend: a multi-push, multi-pop in-order FIFO of `ALU_RS_t` uops, written by dispatch and drained by the ALU execution stage. Each cycle it exposes the oldest `NUM_POP` entries on its read ports, together with empty and almost-empty flags that the ALU stage decodes into per-unit valids. It retires the prefix of entries the ALU stage pops. All flags come from registered state, so there is no combinational path from push or pop to any flag.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, ≥ `NUM_PUSH` and ≥ `NUM_POP`.
- `NUM_PUSH`, default 2: number of dispatch write ports (`NUM_DP_UOP`).
- `NUM_POP`, default `NUM_ALU`: number of read/pop ports, one per ALU unit.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `push_dp2rs` in `[NUM_PUSH]`: write enables; prefix-contiguous.
- `uop_dp2rs` in `ALU_RS_t [NUM_PUSH]`: uops to write; port 0 is the oldest.
- `fifo_full_rs2dp` out 1: no free entry.
- `fifo_almost_full_rs2dp` out `[NUM_PUSH-1:1]`: bit i asserted when free entries ≤ i.
- `pop_ex2rs` in `[NUM_POP]`: pop requests; prefix-contiguous.
- `alu_uop_rs2ex` out `ALU_RS_t [NUM_POP]`: entry i is the (i+1)-th oldest.
- `fifo_empty_rs2ex` out 1: count == 0.
- `fifo_almost_empty_rs2ex` out `[NUM_POP-1:1]`: bit i asserted when count ≤ i.

## Operation
- State: `wr_ptr`, `rd_ptr` (width `$clog2(DEPTH)`, natural wrap-around), `count` (width `$clog2(DEPTH)+1`), and an unreset storage array.
- Push:
  - Number pushed `np` = popcount of `push_dp2rs`.
  - Entry k goes to `mem[wr_ptr+k]`.
  - `wr_ptr += np`.
- Pop:
  - Number popped `nq` = popcount of `pop_ex2rs`.
  - `rd_ptr += nq`.
- Count update: `count <= count + np - nq`.
- Read ports: `alu_uop_rs2ex[i] = mem[rd_ptr+i]`, a combinational mux from registered pointers.
  - Contents are don't-care where `count ≤ i`.
  - Consumers must gate these ports with the flags.
- Flags are decoded from registered `count` only.
- Protocol rules. Violations are checked by SVA in `rvv_backend_sva.svh` and leave behaviour undefined.
  - Push and pop vectors are prefix-contiguous (no hole: bit i set requires bits i-1..0 set).
  - `np ≤ DEPTH - count`.
  - `nq ≤ count`.
- No bypass in either direction:
  - A pop in cycle t does not create space for a push in cycle t.
  - A push in cycle t is not visible on the read ports until t+1.
- Simultaneous push and pop are both applied in the same cycle, with independent pointers. This includes the case where the FIFO is full and pops, and the case where it is empty while pushing.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `wr_ptr = rd_ptr = count = 0`.
  - `fifo_empty_rs2ex = 1`, all `fifo_almost_empty_rs2ex = 1`.
  - `fifo_full_rs2dp = 0`, all `fifo_almost_full_rs2dp = 0`.
  - Storage is not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Push-to-read latency is 1 cycle: a uop pushed at edge t appears on `alu_uop_rs2ex` after edge t, with `fifo_empty_rs2ex` low.
- Flags update on the same edge as `count`.
- Throughput: up to `NUM_PUSH` pushes and `NUM_POP` pops per cycle, sustained.

## Structure
- Shared package `rvv_backend.svh` holds:
  - `ALU_RS_t`;
  - `NUM_ALU`, `NUM_DP_UOP`, `ALU_RS_DEPTH`;
  - the `MULTI_ALU` define, which gates the almost-empty port.
- Natural sub-module: `rvv_backend_multi_fifo`.
  - Type-parameterized (`parameter type T`), holding the pointer, count and flag logic.
  - `rvv_backend_alu_rs` is a thin instance of it with `T = ALU_RS_t`.
  - The same sub-module is reused by the other PU reservation stations.
- Popcount and pointer-offset adders stay inside the sub-module, with no further hierarchy.

## Test plan
- **Reset:** hold `rst_n` low, then release → `empty = 1`, `almost_empty = 1`, `full = 0`. Push 1 uop, tag 0x11 → next cycle `empty = 0`, `almost_empty[1] = 1`, `alu_uop_rs2ex[0] = 0x11`.
- **Dual push, dual pop:** push tags 0x1..0x8 two per cycle (`DEPTH = 8`) → after 4 cycles `full = 1`, count 8. Pop `2'b11` each cycle → ports show (1,2), (3,4), (5,6), (7,8), then `empty = 1`.
- **Full with simultaneous push and pop:** count 7, push 1 and pop 2 in the same cycle → count 6, `almost_full[1] = 0`, read order preserved.
- **Wrap-around:** perform 20 cycles of random legal push/pop counts (0–2) → read-port sequence matches a scoreboard queue across multiple pointer wraps.
- **Partial pop:** count 3, pop `2'b01` → `rd_ptr` advances by 1 and the new port 0 shows the previous port-1 uop.
- **Asynchronous reset mid-stream:** with count 5, drop `rst_n` between edges → flags go to reset values immediately, without waiting for a clock edge. Subsequent pushes start at index 0.

Source files
------------

// File: rtl/rvv_backend_alu_rs_pkg.sv
// Shared types and sizing constants for the RVV backend ALU reservation station.
package rvv_backend_alu_rs_pkg;

    // Backend sizing
    localparam int NUM_ALU      = 2;
    localparam int NUM_DP_UOP   = 2;
    localparam int ALU_RS_DEPTH = 8;

    // Uop as held in the ALU reservation station
    typedef struct packed {
        logic [7:0]  tag;
        logic [5:0]  funct6;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        logic        vm;
        logic [31:0] rs1_data;
    } alu_rs_t;

endpackage

// File: rtl/rvv_backend_multi_fifo.sv
// Multi-push, multi-pop in-order FIFO shared by the PU reservation stations.
// All flags decode from the registered count. Push and pop never bypass each other.
module rvv_backend_multi_fifo #(
    parameter type T        = logic [7:0],
    parameter int  DEPTH    = 8,
    parameter int  NUM_PUSH = 2,
    parameter int  NUM_POP  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PUSH-1:0] push,
    input  T                    data_in [NUM_PUSH],
    output logic                full,
    output logic [NUM_PUSH-1:1] almost_full,
    input  logic [NUM_POP-1:0]  pop,
    output T                    data_out [NUM_POP],
    output logic                empty,
    output logic [NUM_POP-1:1]  almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] num_push;
    logic [CW-1:0] num_pop;
    logic [CW-1:0] free_cnt;

    // Count how many entries are written and retired this cycle
    always_comb begin
        num_push = '0;
        num_pop  = '0;
        for (int k = 0; k < NUM_PUSH; k++) begin
            if (push[k]) num_push = num_push + CW'(1);
        end
        for (int k = 0; k < NUM_POP; k++) begin
            if (pop[k]) num_pop = num_pop + CW'(1);
        end
    end

    // Write each pushed uop into consecutive slots starting at the write pointer
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PUSH; k++) begin
            if (push[k]) mem[wr_ptr + AW'(k)] <= data_in[k];
        end
    end

    // Advance pointers and occupancy; reset drops every entry at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + num_push[AW-1:0];
            rd_ptr <= rd_ptr + num_pop[AW-1:0];
            count  <= count + num_push - num_pop;
        end
    end

    // Expose the oldest NUM_POP entries from the registered read pointer
    always_comb begin
        for (int i = 0; i < NUM_POP; i++) begin
            data_out[i] = mem[rd_ptr + AW'(i)];
        end
    end

    assign free_cnt = CW'(DEPTH) - count;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    for (genvar i = 1; i < NUM_PUSH; i++) begin : g_almost_full
        assign almost_full[i] = (free_cnt <= CW'(i));
    end

    for (genvar i = 1; i < NUM_POP; i++) begin : g_almost_empty
        assign almost_empty[i] = (count <= CW'(i));
    end

endmodule

// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: a thin wrapper of the shared multi-port FIFO holding ALU uops.
module rvv_backend_alu_rs
    import rvv_backend_alu_rs_pkg::*;
#(
    parameter int DEPTH    = ALU_RS_DEPTH,
    parameter int NUM_PUSH = NUM_DP_UOP,
    parameter int NUM_POP  = NUM_ALU
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PUSH-1:0] push_dp2rs,
    input  alu_rs_t             uop_dp2rs [NUM_PUSH],
    output logic                fifo_full_rs2dp,
    output logic [NUM_PUSH-1:1] fifo_almost_full_rs2dp,
    input  logic [NUM_POP-1:0]  pop_ex2rs,
    output alu_rs_t             alu_uop_rs2ex [NUM_POP],
    output logic                fifo_empty_rs2ex,
    output logic [NUM_POP-1:1]  fifo_almost_empty_rs2ex
);

    rvv_backend_multi_fifo #(
        .T        (alu_rs_t),
        .DEPTH    (DEPTH),
        .NUM_PUSH (NUM_PUSH),
        .NUM_POP  (NUM_POP)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_dp2rs),
        .data_in      (uop_dp2rs),
        .full         (fifo_full_rs2dp),
        .almost_full  (fifo_almost_full_rs2dp),
        .pop          (pop_ex2rs),
        .data_out     (alu_uop_rs2ex),
        .empty        (fifo_empty_rs2ex),
        .almost_empty (fifo_almost_empty_rs2ex)
    );

endmodule
